// File: rtl/resv_pkg.sv
// resv_pkg: shared opcode field widths and tag helpers for the reservation station.
// A tag carries a pending flag in its MSB above the ROB index.
package resv_pkg;

  localparam int OPC_W = 7;
  localparam int F3_W  = 3;
  localparam int F7_W  = 1;

  function automatic int tag_w(input int rob_w);
    return rob_w + 1;
  endfunction

  function automatic int tag_pend_bit(input int rob_w);
    return rob_w;
  endfunction

endpackage

// File: rtl/rs_age_picker.sv
// rs_age_picker: one-hot grant of the oldest ready entry.
// Row i of the age matrix has bit j set when entry j is older than entry i.
module rs_age_picker
  import resv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH*DEPTH-1:0] i_age,
  input  logic [DEPTH-1:0]       i_ready,
  output logic [DEPTH-1:0]       o_grant,
  output logic                   o_valid
);

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      o_grant[i] = i_ready[i] &&
        ((i_age[i*DEPTH +: DEPTH] & i_ready) == '0);
  end

  assign o_valid = |i_ready;

endmodule

// File: rtl/resv_station.sv
// resv_station: ALU reservation station with CDB wakeup and oldest-first dispatch.
// Define RESV_STATION_FAST_WAKEUP_EN to dispatch entries in their broadcast cycle.
module resv_station
  import resv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ROB_W = 4,
  parameter int XLEN  = 32,
  parameter int NCDB  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  output logic                    nxt_full,
  input  logic                    issue_valid,
  input  logic [ROB_W-1:0]        issue_rob_pos,
  input  logic [OPC_W-1:0]        issue_opcode,
  input  logic [F3_W-1:0]         issue_funct3,
  input  logic [F7_W-1:0]         issue_funct7,
  input  logic [XLEN-1:0]         issue_src1_val,
  input  logic [XLEN-1:0]         issue_src2_val,
  input  logic [tag_w(ROB_W)-1:0] issue_src1_tag,
  input  logic [tag_w(ROB_W)-1:0] issue_src2_tag,
  input  logic [XLEN-1:0]         issue_imm,
  input  logic [XLEN-1:0]         issue_pc,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*ROB_W-1:0]   cdb_rob_pos,
  input  logic [NCDB*XLEN-1:0]    cdb_val,
  output logic                    alu_en,
  input  logic                    alu_ready,
  output logic [OPC_W-1:0]        alu_opcode,
  output logic [F3_W-1:0]         alu_funct3,
  output logic [F7_W-1:0]         alu_funct7,
  output logic [XLEN-1:0]         alu_val1,
  output logic [XLEN-1:0]         alu_val2,
  output logic [XLEN-1:0]         alu_imm,
  output logic [XLEN-1:0]         alu_pc,
  output logic [ROB_W-1:0]        alu_rob_pos
);

  localparam int TW = tag_w(ROB_W);
  localparam int TP = tag_pend_bit(ROB_W);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_age  [DEPTH];
  logic [TW-1:0]    r_tag1 [DEPTH];
  logic [TW-1:0]    r_tag2 [DEPTH];
  logic [XLEN-1:0]  r_val1 [DEPTH];
  logic [XLEN-1:0]  r_val2 [DEPTH];
  logic [XLEN-1:0]  r_imm  [DEPTH];
  logic [XLEN-1:0]  r_pc   [DEPTH];
  logic [OPC_W-1:0] r_opc  [DEPTH];
  logic [F3_W-1:0]  r_f3   [DEPTH];
  logic [F7_W-1:0]  r_f7   [DEPTH];
  logic [ROB_W-1:0] r_rob  [DEPTH];

  logic [XLEN:0]          w_s1 [DEPTH];
  logic [XLEN:0]          w_s2 [DEPTH];
  logic [XLEN-1:0]        w_dv1 [DEPTH];
  logic [XLEN-1:0]        w_dv2 [DEPTH];
  logic [XLEN:0]          w_is1;
  logic [XLEN:0]          w_is2;
  logic [DEPTH-1:0]       w_ready;
  logic [DEPTH-1:0]       w_grant;
  logic [DEPTH*DEPTH-1:0] w_age_flat;
  logic                   w_pick_v;
  logic [IW-1:0]          w_pick;
  logic [IW-1:0]          w_alloc;
  logic                   w_alloc_ok;
  logic [CW-1:0]          w_free;
  logic                   w_iss;
  logic                   w_ld;

  // {hit, value}; descending scan lets the lowest matching port win
  function automatic logic [XLEN:0] snoop(input logic [TW-1:0] tag);
    snoop = '0;
    for (int k = NCDB - 1; k >= 0; k--)
      if (cdb_valid[k] &&
          tag == {1'b1, cdb_rob_pos[k*ROB_W +: ROB_W]})
        snoop = {1'b1, cdb_val[k*XLEN +: XLEN]};
  endfunction

  always_comb begin
    w_is1 = snoop(issue_src1_tag);
    w_is2 = snoop(issue_src2_tag);
    for (int i = 0; i < DEPTH; i++) begin
      w_s1[i] = snoop(r_tag1[i]);
      w_s2[i] = snoop(r_tag2[i]);
      w_age_flat[i*DEPTH +: DEPTH] = r_age[i];
`ifdef RESV_STATION_FAST_WAKEUP_EN
      w_ready[i] = r_busy[i] &&
        (!r_tag1[i][TP] || w_s1[i][XLEN]) &&
        (!r_tag2[i][TP] || w_s2[i][XLEN]);
      w_dv1[i] = w_s1[i][XLEN] ? w_s1[i][XLEN-1:0] : r_val1[i];
      w_dv2[i] = w_s2[i][XLEN] ? w_s2[i][XLEN-1:0] : r_val2[i];
`else
      w_ready[i] = r_busy[i] && !r_tag1[i][TP] && !r_tag2[i][TP];
      w_dv1[i] = r_val1[i];
      w_dv2[i] = r_val2[i];
`endif
    end
  end

  always_comb begin
    w_free = '0;
    w_alloc = '0;
    w_alloc_ok = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free = w_free + 1'b1;
        w_alloc = IW'(i);
        w_alloc_ok = 1'b1;
      end
    end
  end

  rs_age_picker #(.DEPTH(DEPTH)) u_pick (
    .i_age   (w_age_flat),
    .i_ready (w_ready),
    .o_grant (w_grant),
    .o_valid (w_pick_v)
  );

  always_comb begin
    w_pick = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_grant[i]) w_pick = IW'(i);
  end

  assign w_iss = issue_valid && w_alloc_ok;
  assign w_ld = !alu_en || alu_ready;
  assign nxt_full = (w_free == CW'(0)) ||
    ((w_free == CW'(1)) && issue_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
      alu_en <= 1'b0;
      alu_opcode <= '0;
      alu_funct3 <= '0;
      alu_funct7 <= '0;
      alu_val1 <= '0;
      alu_val2 <= '0;
      alu_imm <= '0;
      alu_pc <= '0;
      alu_rob_pos <= '0;
    end else if (flush) begin
      r_busy <= '0;
      alu_en <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && w_s1[i][XLEN]) begin
          r_val1[i] <= w_s1[i][XLEN-1:0];
          r_tag1[i][TP] <= 1'b0;
        end
        if (r_busy[i] && w_s2[i][XLEN]) begin
          r_val2[i] <= w_s2[i][XLEN-1:0];
          r_tag2[i][TP] <= 1'b0;
        end
      end
      if (w_ld) begin
        alu_en <= w_pick_v;
        if (w_pick_v) begin
          alu_opcode <= r_opc[w_pick];
          alu_funct3 <= r_f3[w_pick];
          alu_funct7 <= r_f7[w_pick];
          alu_val1 <= w_dv1[w_pick];
          alu_val2 <= w_dv2[w_pick];
          alu_imm <= r_imm[w_pick];
          alu_pc <= r_pc[w_pick];
          alu_rob_pos <= r_rob[w_pick];
          r_busy[w_pick] <= 1'b0;
        end
      end
      // stale column bits from a previous occupant must not outrank the newcomer
      if (w_iss) begin
        for (int i = 0; i < DEPTH; i++) r_age[i][w_alloc] <= 1'b0;
        r_age[w_alloc] <= r_busy;
        r_busy[w_alloc] <= 1'b1;
        r_tag1[w_alloc] <= w_is1[XLEN] ?
          {1'b0, issue_src1_tag[TP-1:0]} : issue_src1_tag;
        r_tag2[w_alloc] <= w_is2[XLEN] ?
          {1'b0, issue_src2_tag[TP-1:0]} : issue_src2_tag;
        r_val1[w_alloc] <= w_is1[XLEN] ?
          w_is1[XLEN-1:0] : issue_src1_val;
        r_val2[w_alloc] <= w_is2[XLEN] ?
          w_is2[XLEN-1:0] : issue_src2_val;
        r_imm[w_alloc] <= issue_imm;
        r_pc[w_alloc] <= issue_pc;
        r_opc[w_alloc] <= issue_opcode;
        r_f3[w_alloc] <= issue_funct3;
        r_f7[w_alloc] <= issue_funct7;
        r_rob[w_alloc] <= issue_rob_pos;
      end
    end
  end

endmodule

// File: tb/tb_resv_station.sv
// tb_resv_station: directed vector table plus hand sequences for stall, fill, freeze, flush.
// Honours RESV_STATION_FAST_WAKEUP_EN for wakeup-latency expectations.
module tb_resv_station;

`ifdef RESV_STATION_FAST_WAKEUP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, flush, nxt_full, issue_valid;
  logic [3:0]  issue_rob_pos;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic [0:0]  issue_funct7;
  logic [31:0] issue_src1_val, issue_src2_val, issue_imm, issue_pc;
  logic [4:0]  issue_src1_tag, issue_src2_tag;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_pos;
  logic [63:0] cdb_val;
  logic        alu_en, alu_ready;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [0:0]  alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  int n_tests = 0;
  int n_fail = 0;
  int n_ovf = 0;
  int occ = 0;
  int got = 0;

  always #5 clk = ~clk;

  resv_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .nxt_full(nxt_full), .issue_valid(issue_valid),
    .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .alu_en(alu_en), .alu_ready(alu_ready),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  typedef struct {
    logic        iv;
    logic [3:0]  rob;
    logic [4:0]  t1;
    logic [31:0] v1;
    logic [1:0]  cv;
    logic [7:0]  crob;
    logic [63:0] cval;
    logic        ar;
    logic        en;
    logic [3:0]  erob;
    logic [31:0] ev1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(
    input logic iv, input logic [3:0] rob, input logic [4:0] t1,
    input logic [31:0] v1, input logic [1:0] cv, input logic [7:0] crob,
    input logic [63:0] cval, input logic ar, input logic en,
    input logic [3:0] erob, input logic [31:0] ev1);
    vec_t r;
    r.iv = iv; r.rob = rob; r.t1 = t1; r.v1 = v1;
    r.cv = cv; r.crob = crob; r.cval = cval; r.ar = ar;
    r.en = en; r.erob = erob; r.ev1 = ev1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // src2 is always present and encodes the rob, as does the pc
  task automatic drv(input logic v, input logic [3:0] rob,
                     input logic [4:0] t1, input logic [31:0] v1);
    issue_valid = v;
    issue_rob_pos = rob;
    issue_src1_tag = t1;
    issue_src1_val = v1;
    issue_src2_tag = 5'h00;
    issue_src2_val = 32'hA000 | {28'h0, rob};
    issue_pc = {26'h0, rob, 2'b00};
    issue_imm = 32'h7;
    issue_opcode = 7'h33;
    issue_funct3 = rob[2:0];
    issue_funct7 = rob[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl.push_back(V(1, 5, 0, 'h50, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(1, 6, 0, 'h60, 0, 0, 0, 1, 1, 5, 'h50));
    tbl.push_back(V(1, 7, 0, 'h70, 0, 0, 0, 1, 1, 6, 'h60));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 'h70));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(1, 2, 'h13, 0, 1, 'h03, 'hDEAD, 1, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'hDEAD));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(1, 9, 'h1A, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 3, 'hAA, {32'h222, 32'h111}, 1,
                    FAST, 9, 'h111));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, !FAST, 9, 'h111));
    tbl.push_back(V(1, 8, 'h14, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 2, 'h40, {32'h55, 32'h0}, 1,
                    FAST, 8, 'h55));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, !FAST, 8, 'h55));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(1, 12, 'h1C, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 1, 'h0D, 'h77, 1, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 1, 'h0C, 'h77, 1, FAST, 12, 'h77));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, !FAST, 12, 'h77));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // stall with a younger entry in a lower slot than an older one
    tbl.push_back(V(1, 1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 3, 0, 'h30, 0, 0, 0, 0, 1, 1, 'h10));
    tbl.push_back(V(1, 11, 0, 'hB0, 0, 0, 0, 0, 1, 1, 'h10));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h10));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h10));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h10));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 'h30));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 1, 11, 'hB0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; alu_ready = 1'b1;
    cdb_valid = '0; cdb_rob_pos = '0; cdb_val = '0;
    drv(1, 15, 0, 'hF0);
    tick();
    tick();
    chk("reset alu_en", alu_en, 0);
    chk("reset alu_rob_pos", alu_rob_pos, 0);
    chk("reset alu_val1", alu_val1, 0);
    chk("reset alu_pc", alu_pc, 0);
    chk("reset nxt_full", nxt_full, 0);
    rst = 1'b0;
    drv(0, 0, 0, 0);
    tick();
    chk("reset issue discarded", alu_en, 0);

    foreach (tbl[n]) begin
      drv(tbl[n].iv, tbl[n].rob, tbl[n].t1, tbl[n].v1);
      cdb_valid = tbl[n].cv;
      cdb_rob_pos = tbl[n].crob;
      cdb_val = tbl[n].cval;
      alu_ready = tbl[n].ar;
      tick();
      chk($sformatf("vec%0d alu_en", n), alu_en, tbl[n].en);
      if (tbl[n].en) begin
        chk($sformatf("vec%0d rob", n), alu_rob_pos, tbl[n].erob);
        chk($sformatf("vec%0d val1", n), alu_val1, tbl[n].ev1);
        chk($sformatf("vec%0d val2", n), alu_val2,
            32'hA000 | {28'h0, tbl[n].erob});
        chk($sformatf("vec%0d pc", n), alu_pc,
            {26'h0, tbl[n].erob, 2'b00});
      end
    end
    cdb_valid = '0;

    // freeze: rdy low holds alu_en and drops issues
    alu_ready = 1'b1;
    drv(1, 4, 0, 'h40);
    tick();
    chk("frz issue en", alu_en, 0);
    rdy = 1'b0;
    drv(1, 9, 0, 'h90);
    tick();
    chk("frz no dispatch", alu_en, 0);
    rdy = 1'b1;
    drv(0, 0, 0, 0);
    tick();
    chk("frz resume en", alu_en, 1);
    chk("frz resume rob", alu_rob_pos, 4);
    rdy = 1'b0;
    tick();
    chk("frz hold en", alu_en, 1);
    chk("frz hold rob", alu_rob_pos, 4);
    rdy = 1'b1;
    tick();
    chk("frz ignored issue", alu_en, 0);

    // fill: rob0 parks in the dispatch register, 16 more fill the station
    alu_ready = 1'b0;
    drv(1, 0, 0, 'h100);
    tick();
    for (int i = 1; i <= 17; i++) begin
      drv(1, 4'(i), 0, (i == 17) ? 32'hBAD : 32'h100 + i);
      #1;
      if (occ == 16) begin
        n_ovf++;
        $display("[TB] upstream error: issue presented to a full station");
      end
      chk($sformatf("fill%0d nxt_full", i), nxt_full, (i >= 16));
      if (occ < 16) occ++;
      tick();
    end
    chk("upstream error flagged once", n_ovf, 1);
    drv(0, 0, 0, 0);
    chk("fill parked val1", alu_val1, 'h100);
    alu_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!alu_en) break;
      got++;
      chk($sformatf("drain%0d val1", got), alu_val1, 32'h100 + got);
    end
    chk("drain count", got, 16);

    // flush with rdy low, a pending issue and a held dispatch
    alu_ready = 1'b0;
    drv(1, 0, 0, 'h200);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drv(1, 4'(i), 0, 32'h200 + i);
      tick();
    end
    chk("pre-flush alu_en", alu_en, 1);
    flush = 1'b1;
    rdy = 1'b0;
    alu_ready = 1'b1;
    drv(1, 13, 0, 'hD0);
    tick();
    flush = 1'b0;
    rdy = 1'b1;
    drv(0, 0, 0, 0);
    #1;
    chk("flush alu_en", alu_en, 0);
    chk("flush nxt_full", nxt_full, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("flush stale%0d", c), alu_en, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
